stim_pulse_monitor: RTL
=======================

Name: stim_pulse_monitor

Overview:
- Passive receiver for the biphasic stimulation waveform interface (sink, src, amp_dout1, amp_dout2, done_f) driven by the Signalgenerator waveform block.
- Decodes one cathodic / interphase / anodic sequence per stimulation event and measures cathodic width, interphase gap, anodic width, current codes and electrode selects.
- Flags protocol violations and hands one result record per pulse to the control/readout logic through a valid/ack handshake.
- Used in-system for self-check and as the checker in the stimulation subsystem bench.

Parameters:
- CNT_W, 12, width of all width/gap counters and result fields.
- IPD_MAX, 255, maximum interphase gap in cycles before the timeout error.
- CHG_TOL, 8, allowed |cathodic charge - anodic charge| for balance_ok (current-code·cycles).

Ports:
- clk  in  1  system clock (1 MHz)
- reset  in  1  synchronous, active-high reset
- sink  in  6  cathodic current code, nonzero = cathodic phase active
- src  in  6  anodic current code, nonzero = anodic phase active
- amp_dout1  in  4  electrode select 1
- amp_dout2  in  4  electrode select 2
- done_f  in  1  generator end-of-pulse strobe
- meas_valid  out  1  result record valid
- meas_ack  in  1  consumer accepts record
- kath_width  out  CNT_W  cycles sink was nonzero
- ipd_width  out  CNT_W  cycles between sink falling and src rising
- ano_width  out  CNT_W  cycles src was nonzero
- kath_level  out  6  sink code sampled on first cathodic cycle
- ano_level  out  6  src code sampled on first anodic cycle
- elec1  out  4  amp_dout1 sampled on first cathodic cycle
- elec2  out  4  amp_dout2 sampled on first cathodic cycle
- err  out  5  {overrun, done_missing, ipd_timeout, level_change, overlap}
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: synchronous, active-high. All outputs 0, state IDLE, counters 0.
- FSM states: IDLE, KATH, IPD, ANO, CHECK.
- IDLE -> KATH when sink != 0.
  - Load kath cnt = 1, latch kath_level, elec1, elec2.
  - Clear the working error bits except overrun.
- KATH:
  - sink != 0: increment count; saturate at all-ones.
  - sink != kath_level: set level_change.
  - sink == 0: -> IPD with ipd cnt = 1.
- IPD:
  - src != 0: -> ANO with ano cnt = 1, latch ano_level.
  - sink != 0 again: set level_change and stay in IPD.
  - ipd cnt reaches IPD_MAX: set ipd_timeout, -> CHECK.
  - Otherwise increment.
- ANO:
  - src != 0: increment count; saturate.
  - src != ano_level: set level_change.
  - src == 0: -> CHECK.
    - On that same cycle done_f must be 1 (generator asserts done_f the cycle src drops); if not, set done_missing.
- CHECK: one cycle; load output record, -> IDLE.
  - meas_valid rises on the cycle after CHECK, i.e. 2 cycles after the first src == 0 cycle.
- Overlap: sink != 0 && src != 0 in any state sets overlap. The FSM follows sink precedence.
- Handshake:
  - meas_valid holds the record until a cycle with meas_ack = 1, then drops next cycle.
  - Record load while meas_valid = 1 and no ack in the same cycle: overwrite and set overrun.
  - Load and ack in the same cycle: new record, meas_valid stays 1, no overrun.
  - overrun clears only on the accepted ack.
- done_f seen in IDLE or KATH is ignored.
- Counter saturation: widths clamp at 2^CNT_W-1 with no wrap.
- Reset mid-pulse: back to IDLE. A partially measured pulse is discarded. The next sink rising starts fresh.

Optional Feature:
- STIM_CHARGE_CHECK_EN defined:
  - Extra outputs kath_charge and ano_charge (CNT_W+6 bits, width × level) and balance_ok (1 bit, |difference| <= CHG_TOL).
  - All three are computed in CHECK and added to the record; meas_valid latency is unchanged.
- Undefined: these ports and the multipliers are absent.

Decomposition:
- Package stim_mon_pkg:
  - FSM state enum.
  - Error-bit index constants ERR_OVERLAP..ERR_OVERRUN.
  - Code width constant 6 and select width 4.
- One natural sub-module: stim_width_counter (saturating enable/clear counter, CNT_W), instantiated three times.

Test Plan:
- Generator ktp=10, sktp=5, ipd=3, adp=10, sadp=5, amp1=2, amp3=4:
  - kath_width=10, ipd_width=4, ano_width=11, kath_level=5, ano_level=5, elec1=2, elec2=4, err=0.
  - meas_valid 2 cycles after src falls.
  - With STIM_CHARGE_CHECK_EN: charges 50/55, balance_ok=1.
- Same pulse with meas_ack held 0 and a second pulse sent: overrun=1 and record overwritten. Ack clears meas_valid and overrun.
- Force sink=3 and src=2 for 1 cycle mid-cathodic -> overlap=1. Widths are still reported.
- Sink 8 cycles then no src for 255 cycles -> ipd_timeout=1, ano_width=0, meas_valid=1.
- Anodic end without done_f -> done_missing=1. Sink code changes 5->6 mid-phase -> level_change=1.
- Reset asserted during ANO -> meas_valid stays 0, busy=0. The next clean pulse measures correctly.

Source files
------------

// File: rtl/stim_mon_pkg.sv
// Shared types and constants for the biphasic stimulation pulse monitor.
package stim_mon_pkg;

  localparam int CODE_W = 6;
  localparam int SEL_W  = 4;
  localparam int ERR_W  = 5;

  localparam int ERR_OVERLAP      = 0;
  localparam int ERR_LEVEL_CHANGE = 1;
  localparam int ERR_IPD_TIMEOUT  = 2;
  localparam int ERR_DONE_MISSING = 3;
  localparam int ERR_OVERRUN      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KATH,
    ST_IPD,
    ST_ANO,
    ST_CHECK
  } state_t;

endpackage

// File: rtl/stim_width_counter.sv
// Saturating phase-width counter: clear, load-with-one, or increment.
module stim_width_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load_one,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr)
      count <= '0;
    else if (load_one)
      count <= CNT_W'(1);
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/stim_pulse_monitor.sv
// Passive decoder/checker for one cathodic/interphase/anodic stimulation pulse.
// Define STIM_CHARGE_CHECK_EN to add per-phase charge and balance reporting.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for sink to go nonzero
// ST_KATH  | cathodic phase, counting sink-active cycles
// ST_IPD   | interphase gap, counting until src rises or timeout
// ST_ANO   | anodic phase, counting src-active cycles
// ST_CHECK | one cycle: publish the result record
module stim_pulse_monitor
  import stim_mon_pkg::*;
#(
  parameter int CNT_W   = 12,
  parameter int IPD_MAX = 255
`ifdef STIM_CHARGE_CHECK_EN
  ,
  parameter int CHG_TOL = 8
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CODE_W-1:0]        sink,
  input  logic [CODE_W-1:0]        src,
  input  logic [SEL_W-1:0]         amp_dout1,
  input  logic [SEL_W-1:0]         amp_dout2,
  input  logic                     done_f,
  output logic                     meas_valid,
  input  logic                     meas_ack,
  output logic [CNT_W-1:0]         kath_width,
  output logic [CNT_W-1:0]         ipd_width,
  output logic [CNT_W-1:0]         ano_width,
  output logic [CODE_W-1:0]        kath_level,
  output logic [CODE_W-1:0]        ano_level,
  output logic [SEL_W-1:0]         elec1,
  output logic [SEL_W-1:0]         elec2,
  output logic [ERR_W-1:0]         err,
`ifdef STIM_CHARGE_CHECK_EN
  output logic [CNT_W+CODE_W-1:0]  kath_charge,
  output logic [CNT_W+CODE_W-1:0]  ano_charge,
  output logic                     balance_ok,
`endif
  output logic                     busy
);

  state_t            state;
  logic [CODE_W-1:0] kath_lvl_q;
  logic [CODE_W-1:0] ano_lvl_q;
  logic [SEL_W-1:0]  elec1_q;
  logic [SEL_W-1:0]  elec2_q;
  logic [ERR_W-2:0]  work_err;
  logic [ERR_W-2:0]  rec_err;
  logic              overrun;

  logic [CNT_W-1:0]  kath_cnt;
  logic [CNT_W-1:0]  ipd_cnt;
  logic [CNT_W-1:0]  ano_cnt;

  logic sink_act, src_act, overlap_now, start, go_ano, ipd_to, accept;

  assign sink_act    = (sink != '0);
  assign src_act     = (src != '0);
  assign overlap_now = sink_act && src_act;
  assign start       = (state == ST_IDLE) && sink_act;
  assign go_ano      = (state == ST_IPD) && src_act && !sink_act;
  assign ipd_to      = (ipd_cnt >= CNT_W'(IPD_MAX));
  assign accept      = meas_valid && meas_ack;
  assign err         = {overrun, rec_err};

  stim_width_counter #(.CNT_W(CNT_W)) u_kath_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (1'b0),
    .load_one (start),
    .inc      ((state == ST_KATH) && sink_act),
    .count    (kath_cnt)
  );

  stim_width_counter #(.CNT_W(CNT_W)) u_ipd_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (start),
    .load_one ((state == ST_KATH) && !sink_act),
    .inc      ((state == ST_IPD) && !go_ano && !ipd_to),
    .count    (ipd_cnt)
  );

  stim_width_counter #(.CNT_W(CNT_W)) u_ano_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (start),
    .load_one (go_ano),
    .inc      ((state == ST_ANO) && src_act),
    .count    (ano_cnt)
  );

`ifdef STIM_CHARGE_CHECK_EN
  localparam int CHG_W = CNT_W + CODE_W;
  logic [CHG_W-1:0] kath_chg, ano_chg, chg_diff;
  assign kath_chg = CHG_W'(kath_cnt) * CHG_W'(kath_lvl_q);
  assign ano_chg  = CHG_W'(ano_cnt) * CHG_W'(ano_lvl_q);
  assign chg_diff = (kath_chg >= ano_chg) ? (kath_chg - ano_chg) : (ano_chg - kath_chg);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      kath_lvl_q <= '0;
      ano_lvl_q  <= '0;
      elec1_q    <= '0;
      elec2_q    <= '0;
      work_err   <= '0;
      rec_err    <= '0;
      overrun    <= 1'b0;
      meas_valid <= 1'b0;
      kath_width <= '0;
      ipd_width  <= '0;
      ano_width  <= '0;
      kath_level <= '0;
      ano_level  <= '0;
      elec1      <= '0;
      elec2      <= '0;
`ifdef STIM_CHARGE_CHECK_EN
      kath_charge <= '0;
      ano_charge  <= '0;
      balance_ok  <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (sink_act) begin
            state      <= ST_KATH;
            busy       <= 1'b1;
            kath_lvl_q <= sink;
            ano_lvl_q  <= '0;
            elec1_q    <= amp_dout1;
            elec2_q    <= amp_dout2;
            work_err   <= '0;
            work_err[ERR_OVERLAP] <= overlap_now;
          end
        end
        ST_KATH: begin
          if (overlap_now) work_err[ERR_OVERLAP] <= 1'b1;
          if (sink_act) begin
            if (sink != kath_lvl_q) work_err[ERR_LEVEL_CHANGE] <= 1'b1;
          end else begin
            state <= ST_IPD;
          end
        end
        ST_IPD: begin
          if (overlap_now) work_err[ERR_OVERLAP] <= 1'b1;
          // Sink has precedence: a returning cathodic code keeps us in the gap.
          if (sink_act) work_err[ERR_LEVEL_CHANGE] <= 1'b1;
          if (go_ano) begin
            state     <= ST_ANO;
            ano_lvl_q <= src;
          end else if (ipd_to) begin
            state <= ST_CHECK;
            work_err[ERR_IPD_TIMEOUT] <= 1'b1;
          end
        end
        ST_ANO: begin
          if (overlap_now) work_err[ERR_OVERLAP] <= 1'b1;
          if (src_act) begin
            if (src != ano_lvl_q) work_err[ERR_LEVEL_CHANGE] <= 1'b1;
          end else begin
            state <= ST_CHECK;
            if (!done_f) work_err[ERR_DONE_MISSING] <= 1'b1;
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (state == ST_CHECK) begin
        meas_valid <= 1'b1;
        kath_width <= kath_cnt;
        ipd_width  <= ipd_cnt;
        ano_width  <= ano_cnt;
        kath_level <= kath_lvl_q;
        ano_level  <= ano_lvl_q;
        elec1      <= elec1_q;
        elec2      <= elec2_q;
        rec_err    <= work_err | {{(ERR_W-2){1'b0}}, overlap_now};
`ifdef STIM_CHARGE_CHECK_EN
        kath_charge <= kath_chg;
        ano_charge  <= ano_chg;
        balance_ok  <= (chg_diff <= CHG_W'(CHG_TOL));
`endif
        // An unread record being replaced is an overrun; a same-cycle ack is not.
        if (meas_valid && !meas_ack) overrun <= 1'b1;
        else if (accept)             overrun <= 1'b0;
      end else if (accept) begin
        meas_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule
